tiny_dnn_stream_ctl: RTL
========================

TINY_DNN_STREAM_CTL -- requirements
Module: tiny_dnn_stream_ctl

Interface
REQ-001 Parameters SHALL be: F_NUM, default 16, number of cores; SRC_LANES, default 4, 16-bit words per source beat; DST_LANES, default 2, 32-bit words per destination beat; SA_W, default 12, buffer address width; PA_W, default 10, parameter address width; GV_W, default $clog2(F_NUM/SRC_LANES), core-group index width.
REQ-002 Ports SHALL be:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
run  in  1  run mode enable; low = soft clear
wwrite  in  1  weight load request
bwrite  in  1  bias load request
ss  in  SA_W  source beats per sample minus 1
ds  in  SA_W  destination beats per sample minus 1
ks  in  PA_W  parameter beats per core group minus 1
src_valid  in  1  source beat valid
src_last  in  1  source beat last
src_ready  out  1  source beat accepted when high with src_valid
dst_valid  out  1  destination beat valid
dst_last  out  1  final destination beat of a sample
dst_ready  in  1  destination sink ready
prm_v  out  GV_W  core group being written
prm_a  out  PA_W  parameter write address
prm_we  out  1  parameter write strobe
src_v  out  1  source buffer write strobe
src_a  out  SA_W  source buffer write address
inp  out  1  source bank being filled
dst_v  out  1  destination buffer read strobe
dst_a  out  SA_W  destination buffer read address
outp  out  1  destination bank being drained
s_init  out  1  one-cycle sample start pulse to execution control
s_fin  in  1  one-cycle sample-done pulse from execution control
execp  out  1  bank under execution
err  out  1  sticky src_last/count mismatch flag

Function
REQ-003 States SHALL be IDLE, PRM, and RUN.
REQ-004 IDLE: wwrite|bwrite with run=0 SHALL go to PRM; run=1 SHALL go to RUN; both asserted together SHALL give PRM priority.
REQ-005 PRM: src_ready=1; each handshake SHALL assert prm_we for that cycle with the current prm_v/prm_a, then increment prm_a.
REQ-006 PRM: at prm_a==ks, prm_a SHALL wrap to 0 and prm_v increment; a handshake at prm_v==F_NUM/SRC_LANES-1 and prm_a==ks SHALL return to IDLE with prm_v=0.
REQ-007 RUN source side: src_ready = !sfull[inp]; each handshake SHALL pulse src_v with src_a, then increment src_a; at src_a==ss, src_a<=0, sfull[inp]<=1, and inp toggles.
REQ-008 RUN execution: with no sample busy, sfull[b] set and dfull[b] clear for b = the next bank in order (banks alternate 0,1,0,...), the block SHALL pulse s_init for one cycle with execp=b and set busy.
REQ-009 s_fin while busy SHALL clear busy and sfull[execp], set dfull[execp], and toggle the next-bank pointer; s_fin while not busy SHALL be ignored.
REQ-010 RUN drain: dst_valid = dfull[outp]; dst_v = dst_valid&dst_ready; dst_a SHALL increment per handshake and hold while stalled; dst_last = dst_valid & (dst_a==ds).
REQ-011 A handshake with dst_last SHALL clear dfull[outp], reset dst_a to 0, and toggle outp.
REQ-012 The same-cycle s_fin setting dfull[x] and drain-complete clearing dfull[y], with x!=y, SHALL both take effect; the same for sfull set/clear.
REQ-013 src_last SHALL be expected exactly on the final beat (PRM: final group/address; RUN: src_a==ss); any mismatch SHALL set err, with no effect on counters; err clears only on reset.
REQ-014 run=0 in RUN SHALL synchronously return to IDLE and clear all counters, flags, bank pointers, and busy; err SHALL hold.
REQ-015 s_init SHALL never be asserted in consecutive cycles; latency SHALL be 1 cycle from the handshake completing a bank to s_init when the bank is eligible.
REQ-016 All counters SHALL be registered; all outputs except src_ready, dst_valid, dst_last, prm_we, src_v, and dst_v SHALL be registered.

Reset
REQ-017 rst_n=0 SHALL asynchronously force IDLE with all counters, flags, pointers, busy, and err at 0; src_ready, dst_valid, and all strobes SHALL read 0.
REQ-018 Release SHALL be synchronous to clk; the first state transition SHALL occur on the second rising edge after deassertion.

Verification
REQ-019 Weight load, F_NUM=16, ks=3: 16 beats with last on beat 16 -> prm_v/prm_a step 0/0..3/3, back to IDLE, src_ready=0, err=0.
REQ-020 Ping-pong, ss=7: 16 back-to-back beats -> no src_ready drop; s_init with execp=0 one cycle after beat 8; inp=0 again after beat 16.
REQ-021 Back-pressure: both banks full, s_fin withheld -> src_ready=0; s_fin -> src_ready=1 the next cycle.
REQ-022 Drain, ds=3, dst_ready toggling 1,0,1,0,...: dst_a 0..3 holds on stalls; dst_last only on beat 4; outp toggles after it.
REQ-023 src_last on beat 5 with ss=7 -> err=1 and stays 1; bank completes at beat 8.
REQ-024 rst_n low mid-drain -> same cycle dst_valid=0, src_ready=0; after release, the state is IDLE with all counters 0.

Source files
------------

// File: rtl/tiny_dnn_stream_ctl.sv
// tiny_dnn_stream_ctl: parameter-load sequencing plus ping-pong source/destination
// bank control for a small DNN accelerator stream interface.
module tiny_dnn_stream_ctl #(
  parameter int unsigned F_NUM     = 16,
  parameter int unsigned SRC_LANES = 4,
  parameter int unsigned DST_LANES = 2,
  parameter int unsigned SA_W      = 12,
  parameter int unsigned PA_W      = 10,
  parameter int unsigned GV_W      = $clog2(F_NUM / SRC_LANES)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic            wwrite,
  input  logic            bwrite,
  input  logic [SA_W-1:0] ss,
  input  logic [SA_W-1:0] ds,
  input  logic [PA_W-1:0] ks,
  input  logic            src_valid,
  input  logic            src_last,
  output logic            src_ready,
  output logic            dst_valid,
  output logic            dst_last,
  input  logic            dst_ready,
  output logic [GV_W-1:0] prm_v,
  output logic [PA_W-1:0] prm_a,
  output logic            prm_we,
  output logic            src_v,
  output logic [SA_W-1:0] src_a,
  output logic            inp,
  output logic            dst_v,
  output logic [SA_W-1:0] dst_a,
  output logic            outp,
  output logic            s_init,
  input  logic            s_fin,
  output logic            execp,
  output logic            err
);

  if ((F_NUM % SRC_LANES) != 0 || DST_LANES == 0) begin : g_bad_params
    $error("tiny_dnn_stream_ctl: F_NUM must be a multiple of SRC_LANES, DST_LANES nonzero");
  end

  localparam logic [GV_W-1:0] LastGrp = GV_W'(F_NUM / SRC_LANES - 1);

  typedef enum logic [1:0] {StIdle, StPrm, StRun} state_e;

  state_e          state_q, state_d;
  logic            live_q;
  logic [GV_W-1:0] prm_v_q, prm_v_d;
  logic [PA_W-1:0] prm_a_q, prm_a_d;
  logic [SA_W-1:0] src_a_q, src_a_d;
  logic [SA_W-1:0] dst_a_q, dst_a_d;
  logic            inp_q, inp_d;
  logic            outp_q, outp_d;
  logic            execp_q, execp_d;
  logic [1:0]      sfull_q, sfull_d;
  logic [1:0]      dfull_q, dfull_d;
  logic            busy_q, busy_d;
  logic            s_init_q, s_init_d;
  logic            err_q, err_d;

  logic            src_hs;
  logic            prm_end;
  logic            src_end;
  logic            fin_ok;
  logic            start;

  assign prm_end = (prm_v_q == LastGrp) && (prm_a_q == ks);
  assign src_end = (src_a_q == ss);

  // State register; live_q holds the FSM for one edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
    end
  end

  // Next-state decode; a load request wins over run when both are raised in idle.
  always_comb begin
    state_d = state_q;
    if (live_q) begin
      unique case (state_q)
        StIdle: begin
          if (wwrite || bwrite) begin
            state_d = StPrm;
          end else if (run) begin
            state_d = StRun;
          end
        end
        StPrm:   if (prm_we && prm_end) state_d = StIdle;
        StRun:   if (!run) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Handshake outputs, combinational from registered state.
  always_comb begin
    src_ready = 1'b0;
    dst_valid = 1'b0;
    unique case (state_q)
      StPrm: src_ready = 1'b1;
      StRun: begin
        src_ready = !sfull_q[inp_q];
        dst_valid = dfull_q[outp_q];
      end
      default: ;
    endcase
    src_hs   = src_valid && src_ready;
    prm_we   = src_hs && (state_q == StPrm);
    src_v    = src_hs && (state_q == StRun);
    dst_v    = dst_valid && dst_ready;
    dst_last = dst_valid && (dst_a_q == ds);
  end

  // Counter, bank-flag and sample-control next state.
  always_comb begin
    prm_v_d  = prm_v_q;
    prm_a_d  = prm_a_q;
    src_a_d  = src_a_q;
    dst_a_d  = dst_a_q;
    inp_d    = inp_q;
    outp_d   = outp_q;
    execp_d  = execp_q;
    sfull_d  = sfull_q;
    dfull_d  = dfull_q;
    busy_d   = busy_q;
    s_init_d = 1'b0;
    err_d    = err_q;

    // Parameter address walk: address within group, then group.
    if (prm_we) begin
      if (prm_a_q == ks) begin
        prm_a_d = '0;
        prm_v_d = prm_end ? '0 : prm_v_q + 1'b1;
      end else begin
        prm_a_d = prm_a_q + 1'b1;
      end
      if (src_last != prm_end) err_d = 1'b1;
    end

    // Source fill; completing a bank marks it full and swaps to the other bank.
    if (src_v) begin
      if (src_end) begin
        src_a_d        = '0;
        sfull_d[inp_q] = 1'b1;
        inp_d          = ~inp_q;
      end else begin
        src_a_d = src_a_q + 1'b1;
      end
      if (src_last != src_end) err_d = 1'b1;
    end

    // Sample done: source bank is consumed, matching destination bank is ready.
    fin_ok = s_fin && busy_q;
    if (fin_ok) begin
      busy_d           = 1'b0;
      sfull_d[execp_q] = 1'b0;
      dfull_d[execp_q] = 1'b1;
      execp_d          = ~execp_q;
    end

    // Drain; the address only moves on an accepted beat.
    if (dst_v) begin
      if (dst_last) begin
        dst_a_d         = '0;
        dfull_d[outp_q] = 1'b0;
        outp_d          = ~outp_q;
      end else begin
        dst_a_d = dst_a_q + 1'b1;
      end
    end

    // Launch from post-update flags so a just-completed bank starts one cycle later.
    start = (state_q == StRun) && run && !busy_d && !s_init_q &&
            sfull_d[execp_d] && !dfull_d[execp_d];
    if (start) begin
      busy_d   = 1'b1;
      s_init_d = 1'b1;
    end

    // Soft clear: leaving run wipes everything except the sticky error.
    if ((state_q == StRun) && !run) begin
      prm_v_d  = '0;
      prm_a_d  = '0;
      src_a_d  = '0;
      dst_a_d  = '0;
      inp_d    = 1'b0;
      outp_d   = 1'b0;
      execp_d  = 1'b0;
      sfull_d  = '0;
      dfull_d  = '0;
      busy_d   = 1'b0;
      s_init_d = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prm_v_q  <= '0;
      prm_a_q  <= '0;
      src_a_q  <= '0;
      dst_a_q  <= '0;
      inp_q    <= 1'b0;
      outp_q   <= 1'b0;
      execp_q  <= 1'b0;
      sfull_q  <= '0;
      dfull_q  <= '0;
      busy_q   <= 1'b0;
      s_init_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      prm_v_q  <= prm_v_d;
      prm_a_q  <= prm_a_d;
      src_a_q  <= src_a_d;
      dst_a_q  <= dst_a_d;
      inp_q    <= inp_d;
      outp_q   <= outp_d;
      execp_q  <= execp_d;
      sfull_q  <= sfull_d;
      dfull_q  <= dfull_d;
      busy_q   <= busy_d;
      s_init_q <= s_init_d;
      err_q    <= err_d;
    end
  end

  assign prm_v  = prm_v_q;
  assign prm_a  = prm_a_q;
  assign src_a  = src_a_q;
  assign dst_a  = dst_a_q;
  assign inp    = inp_q;
  assign outp   = outp_q;
  assign execp  = execp_q;
  assign s_init = s_init_q;
  assign err    = err_q;

endmodule
